// File: rtl/rs_param.sv
// rtl/rs_param.sv - two-pool reservation station (ALU/branch, load/store) with oldest-first issue
// rs_pool holds one pool plus its issue register; rs_param routes dispatch between two pools.

module rs_pool #(
  parameter int DEPTH  = 3,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32,
  parameter int X_W    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic              flush,
  input  logic              alloc,
  input  logic [4:0]        in_op,
  input  logic [TAG_W-1:0]  in_q1,
  input  logic [TAG_W-1:0]  in_q2,
  input  logic [DATA_W-1:0] in_v1,
  input  logic [DATA_W-1:0] in_v2,
  input  logic [TAG_W-1:0]  in_des,
  input  logic [X_W-1:0]    in_x,
  input  logic [TAG_W-1:0]  alu_cdb_tag,
  input  logic [DATA_W-1:0] alu_cdb_data,
  input  logic [TAG_W-1:0]  mem_cdb_tag,
  input  logic [DATA_W-1:0] mem_cdb_data,
  output logic              has_free,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_op,
  output logic [DATA_W-1:0] out_v1,
  output logic [DATA_W-1:0] out_v2,
  output logic [TAG_W-1:0]  out_des,
  output logic [X_W-1:0]    out_x
);
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [4:0]        op_q [DEPTH], op_d [DEPTH];
  logic [TAG_W-1:0]  q1_q [DEPTH], q1_d [DEPTH], q2_q [DEPTH], q2_d [DEPTH];
  logic [TAG_W-1:0]  des_q [DEPTH], des_d [DEPTH];
  logic [DATA_W-1:0] v1_q [DEPTH], v1_d [DEPTH], v2_q [DEPTH], v2_d [DEPTH];
  logic [X_W-1:0]    x_q [DEPTH], x_d [DEPTH];
  // older_q[i][j] set: entry i was allocated before entry j
  logic [DEPTH-1:0]  older_q [DEPTH], older_d [DEPTH];
  logic              valid_q, valid_d;
  logic [4:0]        pop_op_q, pop_op_d;
  logic [DATA_W-1:0] pop_v1_q, pop_v1_d, pop_v2_q, pop_v2_d;
  logic [TAG_W-1:0]  pop_des_q, pop_des_d;
  logic [X_W-1:0]    pop_x_q, pop_x_d;

  logic [DEPTH-1:0]  rdy, sel_oh, free_oh;
  logic              found, load;
  logic [4:0]        sel_op;
  logic [DATA_W-1:0] sel_v1, sel_v2;
  logic [TAG_W-1:0]  sel_des;
  logic [X_W-1:0]    sel_x;

  always_comb begin
    busy_d = busy_q;  op_d = op_q;  q1_d = q1_q;  q2_d = q2_q;  des_d = des_q;
    v1_d = v1_q;  v2_d = v2_q;  x_d = x_q;  older_d = older_q;
    valid_d = valid_q;  pop_op_d = pop_op_q;  pop_v1_d = pop_v1_q;  pop_v2_d = pop_v2_q;
    pop_des_d = pop_des_q;  pop_x_d = pop_x_q;
    rdy = '0;  sel_oh = '0;  free_oh = '0;  found = 1'b0;
    sel_op = '0;  sel_v1 = '0;  sel_v2 = '0;  sel_des = '0;  sel_x = '0;
    load = !valid_q || out_ready;

    for (int i = 0; i < DEPTH; i++) rdy[i] = busy_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
    for (int i = 0; i < DEPTH; i++) begin
      sel_oh[i] = rdy[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && rdy[j] && !older_q[i][j]) sel_oh[i] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy_q[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
      if (sel_oh[i]) begin
        sel_op |= op_q[i];  sel_v1 |= v1_q[i];  sel_v2 |= v2_q[i];
        sel_des |= des_q[i];  sel_x |= x_q[i];
      end
    end

    if (!pause) begin
      if (load) begin
        valid_d = |sel_oh;
        if (|sel_oh) begin
          pop_op_d = sel_op;  pop_v1_d = sel_v1;  pop_v2_d = sel_v2;
          pop_des_d = sel_des;  pop_x_d = sel_x;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (sel_oh[i]) begin
            busy_d[i]  = 1'b0;
            older_d[i] = '0;
            for (int j = 0; j < DEPTH; j++) older_d[j][i] = 1'b0;
          end
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (q1_q[i] != '0 && q1_q[i] == alu_cdb_tag) begin
          v1_d[i] = alu_cdb_data;  q1_d[i] = '0;
        end else if (q1_q[i] != '0 && q1_q[i] == mem_cdb_tag) begin
          v1_d[i] = mem_cdb_data;  q1_d[i] = '0;
        end
        if (q2_q[i] != '0 && q2_q[i] == alu_cdb_tag) begin
          v2_d[i] = alu_cdb_data;  q2_d[i] = '0;
        end else if (q2_q[i] != '0 && q2_q[i] == mem_cdb_tag) begin
          v2_d[i] = mem_cdb_data;  q2_d[i] = '0;
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc && free_oh[i]) begin
          busy_d[i] = 1'b1;  op_d[i] = in_op;  des_d[i] = in_des;  x_d[i] = in_x;
          v1_d[i] = in_v1;  q1_d[i] = in_q1;  v2_d[i] = in_v2;  q2_d[i] = in_q2;
          if (in_q1 != '0 && in_q1 == alu_cdb_tag) begin
            v1_d[i] = alu_cdb_data;  q1_d[i] = '0;
          end else if (in_q1 != '0 && in_q1 == mem_cdb_tag) begin
            v1_d[i] = mem_cdb_data;  q1_d[i] = '0;
          end
          if (in_q2 != '0 && in_q2 == alu_cdb_tag) begin
            v2_d[i] = alu_cdb_data;  q2_d[i] = '0;
          end else if (in_q2 != '0 && in_q2 == mem_cdb_tag) begin
            v2_d[i] = mem_cdb_data;  q2_d[i] = '0;
          end
          older_d[i] = '0;
          for (int j = 0; j < DEPTH; j++) older_d[j][i] = (j != i) && busy_d[j];
        end
      end
    end

    if (flush) begin
      busy_d  = '0;
      valid_d = 1'b0;
      for (int i = 0; i < DEPTH; i++) older_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;  older_q <= '{default: '0};
      op_q <= '{default: '0};  q1_q <= '{default: '0};  q2_q <= '{default: '0};
      des_q <= '{default: '0};  v1_q <= '{default: '0};  v2_q <= '{default: '0};
      x_q <= '{default: '0};
      valid_q <= 1'b0;  pop_op_q <= 5'b11111;  pop_v1_q <= '0;  pop_v2_q <= '0;
      pop_des_q <= '0;  pop_x_q <= '0;
    end else begin
      busy_q <= busy_d;  older_q <= older_d;
      op_q <= op_d;  q1_q <= q1_d;  q2_q <= q2_d;  des_q <= des_d;
      v1_q <= v1_d;  v2_q <= v2_d;  x_q <= x_d;
      valid_q <= valid_d;  pop_op_q <= pop_op_d;  pop_v1_q <= pop_v1_d;
      pop_v2_q <= pop_v2_d;  pop_des_q <= pop_des_d;  pop_x_q <= pop_x_d;
    end
  end

  assign has_free  = ~&busy_q;
  assign out_valid = valid_q;
  assign out_op    = pop_op_q;
  assign out_v1    = pop_v1_q;
  assign out_v2    = pop_v2_q;
  assign out_des   = pop_des_q;
  assign out_x     = pop_x_q;
endmodule

module rs_param #(
  parameter int ALU_DEPTH = 3,
  parameter int MEM_DEPTH = 3,
  parameter int TAG_W     = 3,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic              in_is_branch,
  input  logic [TAG_W-1:0]  in_des,
  input  logic [DATA_W-1:0] in_v1,
  input  logic [DATA_W-1:0] in_v2,
  input  logic [TAG_W-1:0]  in_q1,
  input  logic [TAG_W-1:0]  in_q2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [TAG_W-1:0]  alu_cdb_tag,
  input  logic [DATA_W-1:0] alu_cdb_data,
  input  logic [TAG_W-1:0]  mem_cdb_tag,
  input  logic [DATA_W-1:0] mem_cdb_data,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [4:0]        alu_op,
  output logic [DATA_W-1:0] alu_value1,
  output logic [DATA_W-1:0] alu_value2,
  output logic [TAG_W-1:0]  alu_des,
  output logic              alu_is_branch,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [4:0]        mem_op,
  output logic [DATA_W-1:0] mem_value1,
  output logic [DATA_W-1:0] mem_value2,
  output logic [DATA_W-1:0] mem_imm,
  output logic [TAG_W-1:0]  mem_des
);
  logic is_mem, is_bubble, alu_free, mem_free, fire;

  // a bubble has no target pool; it is accepted and dropped so dispatch never stalls on it
  assign is_mem    = (in_op >= 5'd18) && (in_op <= 5'd25);
  assign is_bubble = (in_op == 5'b11111);
  assign in_ready  = rst && !pause && !flush && (is_bubble || (is_mem ? mem_free : alu_free));
  assign fire      = in_valid && in_ready && !is_bubble;

  rs_pool #(.DEPTH(ALU_DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .X_W(1)) u_alu (
    .clk(clk), .rst(rst), .pause(pause), .flush(flush), .alloc(fire && !is_mem),
    .in_op(in_op), .in_q1(in_q1), .in_q2(in_q2), .in_v1(in_v1), .in_v2(in_v2),
    .in_des(in_des), .in_x(in_is_branch),
    .alu_cdb_tag(alu_cdb_tag), .alu_cdb_data(alu_cdb_data),
    .mem_cdb_tag(mem_cdb_tag), .mem_cdb_data(mem_cdb_data),
    .has_free(alu_free), .out_valid(alu_valid), .out_ready(alu_ready),
    .out_op(alu_op), .out_v1(alu_value1), .out_v2(alu_value2), .out_des(alu_des),
    .out_x(alu_is_branch)
  );

  rs_pool #(.DEPTH(MEM_DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .X_W(DATA_W)) u_mem (
    .clk(clk), .rst(rst), .pause(pause), .flush(flush), .alloc(fire && is_mem),
    .in_op(in_op), .in_q1(in_q1), .in_q2(in_q2), .in_v1(in_v1), .in_v2(in_v2),
    .in_des(in_des), .in_x(in_imm),
    .alu_cdb_tag(alu_cdb_tag), .alu_cdb_data(alu_cdb_data),
    .mem_cdb_tag(mem_cdb_tag), .mem_cdb_data(mem_cdb_data),
    .has_free(mem_free), .out_valid(mem_valid), .out_ready(mem_ready),
    .out_op(mem_op), .out_v1(mem_value1), .out_v2(mem_value2), .out_des(mem_des),
    .out_x(mem_imm)
  );
endmodule

// File: tb/tb_rs_param.sv
// tb/tb_rs_param.sv - scoreboard bench for rs_param against an age-ordered queue model
module tb_rs_param;
  localparam int AD = 4, MD = 2, TW = 3, DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, pause, flush, in_valid, in_ready, in_is_branch;
  logic [4:0] in_op;
  logic [TW-1:0] in_des, in_q1, in_q2, alu_cdb_tag, mem_cdb_tag;
  logic [DW-1:0] in_v1, in_v2, in_imm, alu_cdb_data, mem_cdb_data;
  logic alu_valid, alu_ready, alu_is_branch, mem_valid, mem_ready;
  logic [4:0] alu_op, mem_op;
  logic [DW-1:0] alu_value1, alu_value2, mem_value1, mem_value2, mem_imm;
  logic [TW-1:0] alu_des, mem_des;

  rs_param #(.ALU_DEPTH(AD), .MEM_DEPTH(MD), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .pause(pause), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_is_branch(in_is_branch), .in_des(in_des), .in_v1(in_v1), .in_v2(in_v2),
    .in_q1(in_q1), .in_q2(in_q2), .in_imm(in_imm),
    .alu_cdb_tag(alu_cdb_tag), .alu_cdb_data(alu_cdb_data),
    .mem_cdb_tag(mem_cdb_tag), .mem_cdb_data(mem_cdb_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op), .alu_value1(alu_value1),
    .alu_value2(alu_value2), .alu_des(alu_des), .alu_is_branch(alu_is_branch),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_op(mem_op), .mem_value1(mem_value1),
    .mem_value2(mem_value2), .mem_imm(mem_imm), .mem_des(mem_des)
  );

  typedef struct {
    logic [4:0] op; logic [DW-1:0] v1, v2, imm; logic [TW-1:0] q1, q2, des; logic br;
  } ent_t;

  ent_t apool[$], mpool[$], a_exp[$], m_exp[$];
  bit a_valid = 0, m_valid = 0, a_cur = 0, m_cur = 0, exp_in_ready = 0, armed = 0;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wake(inout logic [TW-1:0] q, inout logic [DW-1:0] v);
    if (q != 0 && q == alu_cdb_tag) begin v = alu_cdb_data; q = 0; end
    else if (q != 0 && q == mem_cdb_tag) begin v = mem_cdb_data; q = 0; end
  endtask

  // Reference: each pool is a list in allocation order; issue takes the first operand-complete one.
  task automatic model_step();
    ent_t e;
    int idx;
    bit is_mem, bub, fits;
    armed = 1;
    a_cur = a_valid;
    m_cur = m_valid;
    is_mem = (in_op >= 18) && (in_op <= 25);
    bub = (in_op == 31);
    fits = bub ? 1'b1 : is_mem ? (mpool.size() < MD) : (apool.size() < AD);
    exp_in_ready = rst && !pause && !flush && fits;
    if (!rst || flush) begin
      apool.delete(); mpool.delete(); a_exp.delete(); m_exp.delete();
      a_valid = 0; m_valid = 0;
      return;
    end
    if (pause) return;
    if (!a_valid || alu_ready) begin
      idx = -1;
      for (int i = 0; i < apool.size(); i++)
        if (idx < 0 && apool[i].q1 == 0 && apool[i].q2 == 0) idx = i;
      a_valid = (idx >= 0);
      if (idx >= 0) begin a_exp.push_back(apool[idx]); apool.delete(idx); end
    end
    if (!m_valid || mem_ready) begin
      idx = -1;
      for (int i = 0; i < mpool.size(); i++)
        if (idx < 0 && mpool[i].q1 == 0 && mpool[i].q2 == 0) idx = i;
      m_valid = (idx >= 0);
      if (idx >= 0) begin m_exp.push_back(mpool[idx]); mpool.delete(idx); end
    end
    for (int i = 0; i < apool.size(); i++) begin
      e = apool[i]; wake(e.q1, e.v1); wake(e.q2, e.v2); apool[i] = e;
    end
    for (int i = 0; i < mpool.size(); i++) begin
      e = mpool[i]; wake(e.q1, e.v1); wake(e.q2, e.v2); mpool[i] = e;
    end
    if (in_valid && exp_in_ready && !bub) begin
      e.op = in_op; e.des = in_des;
      e.q1 = in_q1; e.v1 = in_v1; wake(e.q1, e.v1);
      e.q2 = in_q2; e.v2 = in_v2; wake(e.q2, e.v2);
      e.imm = is_mem ? in_imm : '0;
      e.br = is_mem ? 1'b0 : in_is_branch;
      if (is_mem) mpool.push_back(e); else apool.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (armed) begin
      chk("in_ready", in_ready, exp_in_ready);
      chk("alu_valid", alu_valid, a_cur);
      chk("mem_valid", mem_valid, m_cur);
      if (rst && !flush && !pause && alu_valid && alu_ready) begin
        if (a_exp.size() == 0) chk("alu_unexpected_issue", 1, 0);
        else begin
          e = a_exp.pop_front();
          chk("alu_op", alu_op, e.op); chk("alu_value1", alu_value1, e.v1);
          chk("alu_value2", alu_value2, e.v2); chk("alu_des", alu_des, e.des);
          chk("alu_is_branch", alu_is_branch, e.br);
        end
      end
      if (rst && !flush && !pause && mem_valid && mem_ready) begin
        if (m_exp.size() == 0) chk("mem_unexpected_issue", 1, 0);
        else begin
          e = m_exp.pop_front();
          chk("mem_op", mem_op, e.op); chk("mem_value1", mem_value1, e.v1);
          chk("mem_value2", mem_value2, e.v2); chk("mem_imm", mem_imm, e.imm);
          chk("mem_des", mem_des, e.des);
        end
      end
    end
  end

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1; pause = 0; flush = 0; in_valid = 0; in_op = 5'd31; in_is_branch = 0;
    in_des = 0; in_v1 = 0; in_v2 = 0; in_q1 = 0; in_q2 = 0; in_imm = 0;
    alu_cdb_tag = 0; alu_cdb_data = 0; mem_cdb_tag = 0; mem_cdb_data = 0;
    alu_ready = 1; mem_ready = 1;
  endtask

  task automatic disp(input logic [4:0] op, input logic [TW-1:0] q1, input logic [DW-1:0] v1,
                      input logic [TW-1:0] q2, input logic [DW-1:0] v2,
                      input logic [TW-1:0] des, input logic [DW-1:0] imm);
    in_valid = 1; in_op = op; in_q1 = q1; in_v1 = v1; in_q2 = q2; in_v2 = v2;
    in_des = des; in_imm = imm; in_is_branch = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 0; tick(); tick(); rst = 1;
  endtask

  initial begin
    do_reset();
    chk("rst_alu_valid", alu_valid, 0); chk("rst_mem_valid", mem_valid, 0);
    chk("rst_alu_op", alu_op, 5'd31); chk("rst_mem_op", mem_op, 5'd31);
    chk("rst_alu_value1", alu_value1, 0); chk("rst_mem_imm", mem_imm, 0);

    // ADD with both operands ready issues one cycle after dispatch
    disp(5'd0, 0, 5, 0, 7, 2, 0); tick();
    idle(); tick();
    chk("t1_valid", alu_valid, 1); chk("t1_op", alu_op, 0);
    chk("t1_v1", alu_value1, 5); chk("t1_v2", alu_value2, 7); chk("t1_des", alu_des, 2);
    idle(); tick(); tick();

    // LW waiting on tag 4, woken by the memory CDB
    disp(5'd20, 4, 0, 0, 3, 1, 32'h44); tick();
    idle(); tick(); tick();
    chk("t2_wait", mem_valid, 0);
    mem_cdb_tag = 4; mem_cdb_data = 32'h100; tick();
    idle(); tick();
    chk("t2_valid", mem_valid, 1); chk("t2_v1", mem_value1, 32'h100); chk("t2_imm", mem_imm, 32'h44);
    tick(); tick();

    // fill the ALU pool on tag 5; oldest-first drain after broadcast
    for (int k = 0; k < AD; k++) begin disp(5'(k), 5, 0, 0, k, TW'(k + 1), 0); tick(); end
    idle(); in_op = 5'd0; #1 chk("t3_alu_full", in_ready, 0);
    in_op = 5'd20; #1 chk("t3_mem_free", in_ready, 1);
    idle(); alu_cdb_tag = 5; alu_cdb_data = 9; tick();
    idle(); tick();
    for (int k = 0; k < AD; k++) begin chk("t3_order", alu_des, k + 1); tick(); end

    // backpressure keeps payload stable
    idle(); alu_ready = 0;
    disp(5'd1, 0, 11, 0, 12, 3, 0); alu_ready = 0; tick();
    disp(5'd2, 0, 13, 0, 14, 4, 0); alu_ready = 0; tick();
    idle(); alu_ready = 0;
    for (int k = 0; k < 3; k++) begin tick(); chk("t4_stable", alu_des, 3); end
    alu_ready = 1; tick();
    chk("t4_next", alu_des, 4);
    idle(); tick(); tick();

    // dispatch-time capture from the ALU CDB
    disp(5'd3, 6, 0, 0, 1, 5, 0); alu_cdb_tag = 6; alu_cdb_data = 32'h66; tick();
    idle(); tick();
    chk("t5_valid", alu_valid, 1); chk("t5_v1", alu_value1, 32'h66);
    tick(); tick();

    // flush with full pools and held outputs; concurrent dispatch dropped
    for (int k = 0; k <= AD; k++) begin disp(5'd4, 0, k, 0, 0, 1, 0); alu_ready = 0; mem_ready = 0; tick(); end
    for (int k = 0; k <= MD; k++) begin disp(5'd18, 0, k, 0, 0, 2, 7); alu_ready = 0; mem_ready = 0; tick(); end
    disp(5'd0, 0, 1, 0, 1, 6, 0); flush = 1; tick();
    chk("t6_alu_valid", alu_valid, 0); chk("t6_mem_valid", mem_valid, 0);
    idle(); in_op = 5'd0; #1 chk("t6_in_ready", in_ready, 1);
    idle(); tick(); chk("t6_dropped", alu_valid, 0);

    // reset mid-stream
    disp(5'd5, 0, 1, 0, 1, 3, 0); tick(); idle(); tick();
    rst = 0; tick(); idle();
    chk("t6r_valid", alu_valid, 0); chk("t6r_op", alu_op, 5'd31);
    tick();

    // pause freezes everything including CDB capture
    disp(5'd6, 0, 1, 0, 1, 1, 0); alu_ready = 0; tick();
    disp(5'd7, 0, 2, 0, 2, 2, 0); alu_ready = 0; tick();
    disp(5'd8, 3, 0, 0, 2, 5, 0); pause = 1; alu_cdb_tag = 3; alu_cdb_data = 1; tick(); tick();
    chk("t6p_des", alu_des, 1); chk("t6p_valid", alu_valid, 1);
    idle(); tick();
    chk("t6p_resume", alu_des, 2);
    idle(); tick(); tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) != 0);
      pause = ($urandom_range(0, 19) == 0);
      flush = ($urandom_range(0, 59) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      case ($urandom_range(0, 19))
        0: in_op = 5'd31;
        1, 2, 3, 4, 5, 6, 7, 8: in_op = 5'($urandom_range(18, 25));
        9: in_op = 5'($urandom_range(26, 30));
        default: in_op = 5'($urandom_range(0, 17));
      endcase
      in_is_branch = $urandom_range(0, 1);
      in_des = TW'($urandom);
      in_q1 = ($urandom_range(0, 1) != 0) ? '0 : TW'($urandom);
      in_q2 = ($urandom_range(0, 2) != 0) ? '0 : TW'($urandom);
      in_v1 = $urandom; in_v2 = $urandom; in_imm = $urandom;
      alu_cdb_tag = TW'($urandom); alu_cdb_data = $urandom;
      mem_cdb_tag = ($urandom_range(0, 3) == 0) ? alu_cdb_tag : TW'($urandom);
      mem_cdb_data = $urandom;
      alu_ready = $urandom_range(0, 3) != 0;
      mem_ready = $urandom_range(0, 3) != 0;
      tick();
    end

    idle(); tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
